// File: rtl/hamming15_dec_pipe.sv
// Two-stage pipelined Hamming(15,11) single-error-correcting decoder with
// valid/ready flow control and saturating word/correction counters.
module hamming15_dec_pipe #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [14:0]      code_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [10:0]      data_out,
    output logic             err_flag,
    output logic [3:0]       err_pos,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] corr_cnt
);

    logic        s1_valid;
    logic [14:0] s1_code;
    logic        s1_load;
    logic        s2_load;
    logic        out_xfer;
    logic [3:0]  syn;
    logic [14:0] fixed;
    logic [10:0] data_fix;

    assign s2_load  = !out_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load;
    assign out_xfer = out_valid && out_ready;

    // Syndrome is the XOR of the positions of all set bits.
    always_comb begin
        syn = '0;
        for (int unsigned i = 0; i < 15; i++) begin
            if (s1_code[4'(i)]) begin
                syn = syn ^ 4'(i + 1);
            end
        end
        fixed = s1_code;
        if (syn != '0) begin
            fixed = s1_code ^ (15'(1) << (syn - 4'd1));
        end
        data_fix = {fixed[14:8], fixed[6:4], fixed[2]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_code  <= '0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_code <= code_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            data_out  <= '0;
            err_flag  <= 1'b0;
            err_pos   <= '0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                data_out <= data_fix;
                err_flag <= (syn != '0);
                err_pos  <= syn;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt <= '0;
            corr_cnt <= '0;
        end else if (clr_cnt) begin
            word_cnt <= '0;
            corr_cnt <= '0;
        end else if (out_xfer) begin
            if (word_cnt != '1) begin
                word_cnt <= word_cnt + 1'b1;
            end
            if (err_flag && corr_cnt != '1) begin
                corr_cnt <= corr_cnt + 1'b1;
            end
        end
    end

endmodule
